// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 bitstream receiver that decodes GRB pixels into a RAM write port.
// Define WS2812_RX_FORWARD_EN to regenerate the daisy-chain output on dout.
module ws2812_rx #(
  parameter int T1_THRESH  = 20,
  parameter int MIN_HIGH   = 5,
  parameter int MAX_HIGH   = 50,
  parameter int GAP_CYCLES = 2500,
  parameter int ADDR_W     = 7
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              din,
  output logic [23:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_we,
  output logic              frame_done,
  output logic [ADDR_W:0]   pix_count,
  output logic              err_glitch,
  output logic              err_partial,
  output logic              dout
);
  typedef enum logic [2:0] {SYNC, READY, HIGH, LOW, ERROR} state_t;
  localparam logic [12:0] T1   = 13'(T1_THRESH);
  localparam logic [12:0] MINH = 13'(MIN_HIGH);
  localparam logic [12:0] MAXH = 13'(MAX_HIGH);
  localparam logic [12:0] GAP  = 13'(GAP_CYCLES);
  state_t state, state_nx;
  logic s1, s2, din_q, rise_r, fall_r;
  logic [11:0] wcnt;
  logic [12:0] len;
  logic [4:0] bit_cnt;
  logic [ADDR_W:0] pix_cnt;
  logic [23:0] sh, sh_nx;
  logic idle, last, resync, accept, bad, gap, we_nx;
  // len is the width of the current level including the cycle its edge was seen
  assign len = {1'b0, wcnt} + 13'd1;
  assign last = bit_cnt == 5'd23;
  assign sh_nx = {sh[22:0], len >= T1};
  assign idle = state == SYNC || state == READY || state == ERROR;
  assign resync = !din_q && len >= GAP;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= SYNC;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      SYNC, ERROR: state_nx = resync ? READY : state;
      READY:       state_nx = rise_r ? HIGH : READY;
      HIGH:        state_nx = bad ? ERROR : accept ? LOW : HIGH;
      LOW:         state_nx = gap ? READY : rise_r ? HIGH : LOW;
      default:     state_nx = SYNC;
    endcase
  end
  // a fall wins over the stuck-high limit reached in the same cycle
  always_comb begin
    accept = state == HIGH && fall_r && len >= MINH && len <= MAXH;
    bad = state == HIGH && (len > MAXH || (fall_r && len < MINH));
    gap = state == LOW && !rise_r && len >= GAP;
    we_nx = accept && last && !pix_cnt[ADDR_W];
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      din_q <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      wcnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      din_q <= s2;
      rise_r <= s2 & ~din_q;
      fall_r <= ~s2 & din_q;
      wcnt <= (rise_r | fall_r) ? '0 : wcnt + {11'd0, ~&wcnt};
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      bit_cnt <= '0;
      pix_cnt <= '0;
      sh <= '0;
      pix_we <= 1'b0;
      pix_data <= '0;
      pix_addr <= '0;
      frame_done <= 1'b0;
      pix_count <= '0;
      err_glitch <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      bit_cnt <= (idle || gap) ? '0 : accept ? (last ? '0 : bit_cnt + 5'd1) : bit_cnt;
      pix_cnt <= idle ? '0 : (accept && last) ? pix_cnt + {{ADDR_W{1'b0}}, ~pix_cnt[ADDR_W]} : pix_cnt;
      sh <= accept ? sh_nx : sh;
      pix_we <= we_nx;
      pix_data <= we_nx ? sh_nx : pix_data;
      pix_addr <= we_nx ? pix_cnt[ADDR_W-1:0] : pix_addr;
      frame_done <= gap;
      pix_count <= gap ? pix_cnt : pix_count;
      err_glitch <= bad;
      err_partial <= gap && bit_cnt != 5'd0;
    end
`ifdef WS2812_RX_FORWARD_EN
  logic fwd;
  // the first pixel of each frame is consumed here; later bits pass downstream
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      fwd <= 1'b0;
      dout <= 1'b0;
    end else begin
      fwd <= (idle || gap) ? 1'b0 : (accept && last) ? 1'b1 : fwd;
      dout <= fwd & ~idle & din_q;
    end
`else
  assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized WS2812 stimulus with a pulse-level reference model and a scoreboard monitor.
module tb_ws2812_rx;
  localparam int T1_THRESH = 20;
  localparam int MIN_HIGH = 5;
  localparam int MAX_HIGH = 50;
  localparam int GAP = 2500;
  localparam int AW = 7;
  localparam int CAP = 1 << AW;

  typedef struct {
    logic [23:0] d;
    int a;
    int t;
  } pix_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic din = 1'b0;
  logic [23:0] pix_data;
  logic [AW-1:0] pix_addr;
  logic pix_we, frame_done, err_glitch, err_partial, dout;
  logic [AW:0] pix_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  pix_t q_pix[$];
  int q_done[$];
  int q_part[$];
  int q_glit[$];
  pix_t mp;
  logic [23:0] m_cur = '0;
  int m_nb = 0;
  int m_npix = 0;
  bit m_sync = 1'b1;
  bit m_err = 1'b0;
`ifdef WS2812_RX_FORWARD_EN
  int win = 0;
  logic [3:0] dhist = '0;
  always @(posedge sys_clk) dhist <= {dhist[2:0], din};
`endif

  ws2812_rx #(.T1_THRESH(T1_THRESH), .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH),
              .GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din),
    .pix_data(pix_data), .pix_addr(pix_addr), .pix_we(pix_we),
    .frame_done(frame_done), .pix_count(pix_count),
    .err_glitch(err_glitch), .err_partial(err_partial), .dout(dout)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: classify each pulse by its width, group accepted bits into 24-bit pixels.
  task automatic pulse(input int h, input int l);
    int r;
    r = cyc;
    if (!m_sync && !m_err) begin
      if (h < MIN_HIGH || h > MAX_HIGH) begin
        q_glit.push_back(1);
        m_err = 1'b1;
      end else begin
        m_cur = {m_cur[22:0], logic'(h >= T1_THRESH)};
        m_nb++;
        if (m_nb == 24) begin
          if (m_npix < CAP) begin
            mp.d = m_cur;
            mp.a = m_npix;
            mp.t = r + h + 4;
            q_pix.push_back(mp);
            m_npix++;
          end
          m_nb = 0;
        end
      end
    end
    din = 1'b1;
    repeat (h) @(negedge sys_clk);
    din = 1'b0;
    repeat (l) @(negedge sys_clk);
  endtask

  task automatic gap();
    if (m_sync) m_sync = 1'b0;
    else if (m_err) m_err = 1'b0;
    else begin
      q_done.push_back(m_npix);
      if (m_nb != 0) q_part.push_back(1);
    end
    m_nb = 0;
    m_npix = 0;
    m_cur = '0;
    din = 1'b0;
    repeat (GAP + 30) @(negedge sys_clk);
  endtask

  task automatic send_px(input logic [23:0] px, input int mode);
    for (int i = 23; i >= 0; i--) begin
      int h, l;
      h = px[i] ? int'($urandom_range(50, 20)) : int'($urandom_range(19, 5));
      l = int'($urandom_range(12, 2));
      if (mode == 1) begin
        h = px[i] ? 31 : 11;
        l = 55 - h;
      end else if (mode == 2) begin
        h = px[i] ? 20 : 5;
        l = 2;
      end else if (mode == 3) l = 10;
      pulse(h, l);
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++)
      pulse(($urandom & 1) != 0 ? int'($urandom_range(50, 20)) : int'($urandom_range(19, 5)),
            int'($urandom_range(12, 2)));
  endtask

  always @(negedge sys_clk)
    if (sys_rst_n) begin
      if (pix_we) begin
        chk("pix_we_expected", int'(q_pix.size() > 0), 1);
        if (q_pix.size() > 0) begin
          mp = q_pix.pop_front();
          chk("pix_data", int'(pix_data), int'(mp.d));
          chk("pix_addr", int'(pix_addr), mp.a);
          chk("pix_we_latency", cyc, mp.t);
        end
      end
      if (frame_done) begin
        chk("frame_done_expected", int'(q_done.size() > 0), 1);
        if (q_done.size() > 0) chk("pix_count", int'(pix_count), q_done.pop_front());
      end
      if (err_partial) begin
        chk("err_partial_expected", int'(q_part.size() > 0), 1);
        if (q_part.size() > 0) void'(q_part.pop_front());
      end
      if (err_glitch) begin
        chk("err_glitch_expected", int'(q_glit.size() > 0), 1);
        if (q_glit.size() > 0) void'(q_glit.pop_front());
      end
`ifdef WS2812_RX_FORWARD_EN
      if (win == 1) chk("dout_held_low", int'(dout), 0);
      else if (win == 2) chk("dout_forward", int'(dout), int'(dhist[3]));
`else
      chk("dout_tied_low", int'(dout), 0);
`endif
    end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of run, expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    int bnd[4];
    int n;
    bnd = '{5, 19, 20, 50};
    @(negedge sys_clk);
    repeat (20) @(negedge sys_clk) din = logic'($urandom & 1);
    chk("reset_pix_count", int'(pix_count), 0);
    chk("reset_pix_we", int'(pix_we), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_err_glitch", int'(err_glitch), 0);
    chk("reset_pix_data", int'(pix_data), 0);
    sys_rst_n = 1'b1;
    repeat (100) @(negedge sys_clk) din = logic'($urandom & 1);
    gap();
    send_px(24'hFF0055, 0);
    gap();
    for (int i = 0; i < 3; i++) send_px(24'($urandom), 1);
    gap();
    send_bits(12);
    gap();
    for (int i = 0; i < 24; i++) pulse(bnd[i % 4], 3);
    send_px(24'($urandom), 0);
    gap();
    send_bits(10);
    pulse(3, 20);
    send_bits(30);
    gap();
    send_bits(5);
    pulse(60, 20);
    send_bits(30);
    gap();
    n = int'($urandom_range(4, 1));
    for (int i = 0; i < n; i++) send_px(24'($urandom), 0);
    gap();
    send_bits(30);
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    m_sync = 1'b1;
    m_err = 1'b0;
    m_nb = 0;
    m_npix = 0;
    m_cur = '0;
    repeat (3) @(negedge sys_clk);
    chk("midframe_reset_pix_count", int'(pix_count), 0);
    chk("midframe_reset_pix_we", int'(pix_we), 0);
    sys_rst_n = 1'b1;
    gap();
    for (int i = 0; i < 130; i++) send_px(24'(i), 2);
    gap();
`ifdef WS2812_RX_FORWARD_EN
    win = 1;
`endif
    send_px(24'($urandom), 3);
`ifdef WS2812_RX_FORWARD_EN
    win = 2;
`endif
    send_px(24'($urandom), 3);
`ifdef WS2812_RX_FORWARD_EN
    win = 0;
`endif
    gap();
    repeat (20) @(negedge sys_clk);
    chk("pix_queue_drained", q_pix.size(), 0);
    chk("done_queue_drained", q_done.size(), 0);
    chk("partial_queue_drained", q_part.size(), 0);
    chk("glitch_queue_drained", q_glit.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812 bitstream receiver/decoder, the receive-side counterpart of the strip driver. Used for loopback self-test of strip outputs and for accepting a daisy-chained LED input.
- Measures high-pulse widths in sys_clk (50 MHz) cycles and classifies each pulse as a 0 or 1 bit.
- Assembles 24-bit GRB pixels and writes them to a pixel RAM port with an address counter.
- Detects the latch/reset gap (end of frame) and flags malformed pulses or partial pixels.

Parameters:
- T1_THRESH, 20: a high pulse of >= this many cycles is a '1' bit; shorter is a '0' bit.
- MIN_HIGH, 5: a high pulse shorter than this is a glitch error.
- MAX_HIGH, 50: a high pulse longer than this is a stuck-high error.
- GAP_CYCLES, 2500: low time in cycles that marks end of frame (50 us).
- ADDR_W, 7: pixel address width; frame capacity is 2^ADDR_W pixels.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- din  in  1  asynchronous WS2812 data input.
- pix_data  out  24  received pixel in wire order {G,R,B}, MSB first.
- pix_addr  out  ADDR_W  pixel index within the current frame.
- pix_we  out  1  one-cycle write strobe; pix_data and pix_addr are valid while it is high.
- frame_done  out  1  one-cycle pulse at end of frame.
- pix_count  out  ADDR_W+1  number of pixels written in the last completed frame.
- err_glitch  out  1  one-cycle pulse on a pulse-width violation.
- err_partial  out  1  one-cycle pulse when a gap arrives with 1..23 bits pending.
- dout  out  1  forwarded data (see Optional Feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All outputs are registered and reset to 0. State resets to SYNC.
- Input path: din passes through a 2-FF synchronizer, then a registered copy is used for edge detection (rise/fall). No other filtering.
- Counters:
  - 12-bit width counter, saturating at 4095; cleared on every edge.
  - 5-bit bit counter.
  - ADDR_W+1-bit pixel counter.
  - 24-bit shift register, left shift, LSB in.
- States:
  - SYNC: wait for continuous low >= GAP_CYCLES, then go to READY. A rise resets the count. This prevents misalignment when reset is released mid-stream.
  - READY: bit_cnt = 0, pix_cnt = 0. On rise, go to HIGH.
  - HIGH: count cycles.
    - If the count exceeds MAX_HIGH, pulse err_glitch and go to ERROR.
    - On fall with count < MIN_HIGH, pulse err_glitch and go to ERROR.
    - Otherwise shift in (count >= T1_THRESH) and go to LOW.
  - LOW: count low cycles.
    - On rise, go to HIGH.
    - When the count reaches GAP_CYCLES, end the frame: pulse frame_done, load pix_count <= pix_cnt, go to READY.
    - If bit_cnt != 0 at that point, also pulse err_partial and discard the partial bits.
  - ERROR: discard everything. On a low of GAP_CYCLES, go to READY with no frame_done; pix_count is unchanged.
- Pixel emit: on the 24th accepted bit, pix_we = 1 for one cycle with pix_data = shift result and pix_addr = pix_cnt[ADDR_W-1:0]; then pix_cnt increments and bit_cnt returns to 0.
- Latency: pix_we rises 4 sys_clk cycles after din falls on the 24th bit (2 sync + 1 edge + 1 output register).
- Overflow: pixels beyond 2^ADDR_W are not written (pix_we stays low) and pix_cnt saturates at 2^ADDR_W. Overflow is not an error.
- Simultaneous events: a width counter hitting MAX_HIGH on the same cycle as a fall is treated as a valid bit, because the edge has priority.
- Reset mid-frame: immediate return to SYNC; the frame is discarded with no frame_done.

Optional Feature:
- Macro WS2812_RX_FORWARD_EN.
- Defined: dout regenerates the chain output the way a physical WS2812 does.
  - dout is held low while the first pixel of each frame (first 24 bits) is consumed.
  - After that, dout = synchronized din delayed 1 cycle.
  - dout returns to the held-low phase after each gap.
  - In ERROR or SYNC, dout = 0.
- Not defined: dout is tied to 0 and no forwarding logic is built.

Test Plan:
- Reset released while din toggles, then a 2500-cycle low, then 24 bits of 0xFF0055 -> no writes before the gap; afterwards one pix_we with pix_data = 0xFF0055 and pix_addr = 0.
- Bits using high = 11 cycles ('0') and 31 cycles ('1'), total 55 cycles per bit, 3 pixels, then a 2500-cycle low -> pix_addr 0,1,2 in order, frame_done once, pix_count = 3.
- 12 bits then a 2500-cycle low -> err_partial pulse, frame_done pulse, no pix_we; the next frame decodes from bit 0.
- A 3-cycle high mid-pixel and, separately, a 60-cycle high -> err_glitch pulse and no further pix_we until a 2500-cycle gap; no frame_done for that frame.
- 130 pixels -> writes only at addresses 0..127; pix_count = 128 at frame_done.
- With WS2812_RX_FORWARD_EN defined and 2 pixels sent -> dout low for the first 24 bits, then dout matches the second pixel's waveform with a fixed delay. Without the macro, dout = 0 throughout.
